// File: rtl/pipeline_stage_reg.sv
// -----------------------------------------------------------------------------
// pipeline_stage_reg
//
// This is a generic pipeline stage register with a valid/ready handshake on
// both sides. It has an optional skid entry and a synchronous flush. The
// payload is an opaque DATA_W-bit bus. Each pipeline stage packs its own fields
// into that bus.
//
// Parameters
//   DATA_W  payload width in bits. The default is 70 (4 + 32 + 32 + 1 + 1).
//   SKID    1: two entries (main + skid); in_ready comes straight from a flop.
//           0: one entry; in_ready = !out_valid || out_ready (combinational).
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   flush      synchronous flush; drops held entries and the entry offered
//              in the same cycle
//   in_valid   upstream presents in_data
//   in_ready   stage can accept; transfer when in_valid && in_ready
//   in_data    upstream payload
//   out_valid  out_data holds a valid entry
//   out_ready  downstream accepts; transfer when out_valid && out_ready
//   out_data   payload of the oldest entry (main register)
//
// Optional feature (macro PIPELINE_STAGE_REG_STATS_EN)
//   stat_stall  cycles with out_valid && !out_ready, saturating at 32 bits
//   stat_xfer   number of output transfers, saturating at 32 bits
//   Both counters clear on rst and ignore flush.
// -----------------------------------------------------------------------------
module pipeline_stage_reg #(
    parameter int DATA_W = 70,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPELINE_STAGE_REG_STATS_EN
    ,
    output logic [31:0]       stat_stall,
    output logic [31:0]       stat_xfer
`endif
);

    logic in_fire;
    logic out_fire;

    // Upstream sees a fire even while flush is high. The stage just does not
    // store that entry, so upstream must treat it as squashed.
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    generate
        if (SKID != 0) begin : g_skid
            // Encoding: bit0 = main valid, bit1 = skid valid. With this
            // encoding, in_ready and out_valid are plain register bits.
            typedef enum logic [1:0] {
                ST_EMPTY = 2'b00,
                ST_ONE   = 2'b01,
                ST_TWO   = 2'b11
            } state_t;

            state_t            state_q, state_d;
            logic [DATA_W-1:0] m_d_q, m_d_d;
            logic [DATA_W-1:0] s_d_q, s_d_d;
            logic              m_load, s_load;

            assign in_ready  = !state_q[1];
            assign out_valid = state_q[0];
            assign out_data  = m_d_q;

            // State register
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_q <= ST_EMPTY;
                end else begin
                    state_q <= state_d;
                end
            end

            // Data registers. They load only when a new value is needed, so
            // the valid bits are the only qualifier and the data does not
            // toggle needlessly.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    m_d_q <= '0;
                    s_d_q <= '0;
                end else begin
                    if (m_load) begin
                        m_d_q <= m_d_d;
                    end
                    if (s_load) begin
                        s_d_q <= s_d_d;
                    end
                end
            end

            // Next-state logic
            always_comb begin
                state_d = state_q;
                if (flush) begin
                    state_d = ST_EMPTY;
                end else begin
                    case (state_q)
                        ST_EMPTY: begin
                            if (in_fire) begin
                                state_d = ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            if (out_fire && !in_fire) begin
                                state_d = ST_EMPTY;
                            end else if (in_fire && !out_fire) begin
                                state_d = ST_TWO;
                            end
                        end
                        ST_TWO: begin
                            if (out_fire) begin
                                state_d = ST_ONE;
                            end
                        end
                        default: state_d = ST_EMPTY;
                    endcase
                end
            end

            // Datapath enables. The skid entry moves into main only when
            // the main entry leaves, which keeps acceptance order.
            always_comb begin
                m_load = 1'b0;
                s_load = 1'b0;
                m_d_d  = in_data;
                s_d_d  = in_data;
                if (!flush) begin
                    case (state_q)
                        ST_EMPTY: begin
                            m_load = in_fire;
                        end
                        ST_ONE: begin
                            m_load = in_fire && out_fire;
                            s_load = in_fire && !out_fire;
                        end
                        ST_TWO: begin
                            m_load = out_fire;
                            m_d_d  = s_d_q;
                        end
                        default: begin
                            m_load = 1'b0;
                        end
                    endcase
                end
            end
        end else begin : g_single
            logic              m_v_q, m_v_d;
            logic [DATA_W-1:0] m_d_q;
            logic              m_load;

            // A full stage can still accept a new entry in the same cycle
            // that the held entry leaves.
            assign in_ready  = !m_v_q || out_ready;
            assign out_valid = m_v_q;
            assign out_data  = m_d_q;
            assign m_load    = in_fire && !flush;

            always_comb begin
                m_v_d = m_v_q;
                if (flush) begin
                    m_v_d = 1'b0;
                end else if (in_fire) begin
                    m_v_d = 1'b1;
                end else if (out_fire) begin
                    m_v_d = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    m_v_q <= 1'b0;
                    m_d_q <= '0;
                end else begin
                    m_v_q <= m_v_d;
                    if (m_load) begin
                        m_d_q <= in_data;
                    end
                end
            end
        end
    endgenerate

`ifdef PIPELINE_STAGE_REG_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] xfer_cnt_q, xfer_cnt_d;

    // The counters saturate instead of wrapping, so a long run never reads
    // back as a small count.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        xfer_cnt_d  = xfer_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (out_fire && (xfer_cnt_q != 32'hFFFF_FFFF)) begin
            xfer_cnt_d = xfer_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            xfer_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign stat_stall = stall_cnt_q;
    assign stat_xfer  = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stage_reg
//
// Runs one SKID=1 instance and one SKID=0 instance with the same input
// stimulus. Each instance has its own reference model, built as a FIFO queue
// with a capacity of 2 or 1. A compare process checks both instances against
// their models on every falling clock edge. Literal checks in the stimulus pin
// down the specific scenarios.
// -----------------------------------------------------------------------------
module tb_pipeline_stage_reg;
    localparam int W = 70;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data = '0;

    logic         s_in_ready, s_out_valid;
    logic [W-1:0] s_out_data;
    logic         n_in_ready, n_out_valid;
    logic [W-1:0] n_out_data;
`ifdef PIPELINE_STAGE_REG_STATS_EN
    logic [31:0]  s_stall, s_xfer, n_stall, n_xfer;
`endif

    always #5 clk = ~clk;

    pipeline_stage_reg #(.DATA_W(W), .SKID(1)) u_dut_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data)
`ifdef PIPELINE_STAGE_REG_STATS_EN
        , .stat_stall(s_stall), .stat_xfer(s_xfer)
`endif
    );

    pipeline_stage_reg #(.DATA_W(W), .SKID(0)) u_dut_single (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(n_in_ready), .in_data(in_data),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data)
`ifdef PIPELINE_STAGE_REG_STATS_EN
        , .stat_stall(n_stall), .stat_xfer(n_xfer)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] qs[$];
    logic [W-1:0] qn[$];
    logic [31:0]  ms_stall = '0, ms_xfer = '0, mn_stall = '0, mn_xfer = '0;
    bit           m_ir, m_if, m_of;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                qs.delete();
                qn.delete();
                ms_stall = '0; ms_xfer = '0; mn_stall = '0; mn_xfer = '0;
            end else begin
                // Two-entry stage: accepts while it holds fewer than two entries.
                m_ir = (qs.size() < 2);
                m_if = in_valid && m_ir;
                m_of = (qs.size() > 0) && out_ready;
                if ((qs.size() > 0) && !out_ready && ms_stall != 32'hFFFF_FFFF) ms_stall++;
                if (m_of && ms_xfer != 32'hFFFF_FFFF) ms_xfer++;
                if (flush) qs.delete();
                else begin
                    if (m_of) void'(qs.pop_front());
                    if (m_if) qs.push_back(in_data);
                end
                // Single-entry stage: accepts when empty or when its entry leaves.
                m_ir = (qn.size() == 0) || out_ready;
                m_if = in_valid && m_ir;
                m_of = (qn.size() > 0) && out_ready;
                if ((qn.size() > 0) && !out_ready && mn_stall != 32'hFFFF_FFFF) mn_stall++;
                if (m_of && mn_xfer != 32'hFFFF_FFFF) mn_xfer++;
                if (flush) qn.delete();
                else begin
                    if (m_of) void'(qn.pop_front());
                    if (m_if) qn.push_back(in_data);
                end
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("rst_s_out_valid", s_out_valid, 1'b0);
                check("rst_s_out_data", s_out_data, '0);
                check("rst_s_in_ready", s_in_ready, 1'b1);
                check("rst_n_out_valid", n_out_valid, 1'b0);
                check("rst_n_in_ready", n_in_ready, 1'b1);
            end else begin
                check("s_out_valid", s_out_valid, qs.size() > 0);
                if (qs.size() > 0) check("s_out_data", s_out_data, qs[0]);
                check("s_in_ready", s_in_ready, qs.size() < 2);
                check("n_out_valid", n_out_valid, qn.size() > 0);
                if (qn.size() > 0) check("n_out_data", n_out_data, qn[0]);
                check("n_in_ready", n_in_ready, (qn.size() == 0) || out_ready);
`ifdef PIPELINE_STAGE_REG_STATS_EN
                check("s_stat_stall", s_stall, ms_stall);
                check("s_stat_xfer", s_xfer, ms_xfer);
                check("n_stat_stall", n_stall, mn_stall);
                check("n_stat_xfer", n_xfer, mn_xfer);
`endif
            end
        end
    end

    // Apply one cycle of inputs. Returns 1 time unit after the capturing edge.
    task automatic cyc(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
        $display("cycle t=%0t iv=%0b d=%0h ordy=%0b fl=%0b | s: v=%0b d=%0h r=%0b | n: v=%0b d=%0h r=%0b",
                 $time, iv, d, ordy, fl, s_out_valid, s_out_data, s_in_ready,
                 n_out_valid, n_out_data, n_in_ready);
    endtask

    localparam logic [W-1:0] A = 70'h0A, B = 70'h0B, C = 70'h0C, D = 70'h0D;

    initial begin
        // Reset held with an entry offered: nothing may be captured.
        cyc(1'b1, 70'h5, 1'b0, 1'b0);
        cyc(1'b1, 70'h5, 1'b0, 1'b0);
        check("lit_rst_out_valid", s_out_valid, 1'b0);
        check("lit_rst_out_data", s_out_data, '0);
        check("lit_rst_in_ready", s_in_ready, 1'b1);
        rst = 1'b1;
        cyc(1'b1, 70'h5, 1'b0, 1'b0);
        check("lit_first_capture_v", s_out_valid, 1'b1);
        check("lit_first_capture_d", s_out_data, 70'h5);
        check("lit_first_capture_n", n_out_data, 70'h5);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // Streaming: one entry per cycle with one cycle of latency.
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, W'(i), 1'b1, 1'b0);
            check("lit_stream_s", s_out_data, W'(i));
            check("lit_stream_n", n_out_data, W'(i));
            check("lit_stream_rdy", s_in_ready, 1'b1);
        end
        cyc(1'b0, '0, 1'b1, 1'b0);

        // Backpressure: A goes to main, B to skid, C is held upstream.
        cyc(1'b1, A, 1'b0, 1'b0);
        cyc(1'b1, B, 1'b0, 1'b0);
        check("lit_bp_rdy0", s_in_ready, 1'b0);
        check("lit_bp_model_depth", W'(qs.size()), W'(2));
        cyc(1'b1, C, 1'b0, 1'b0);
        check("lit_bp_hold", s_out_data, A);
        cyc(1'b1, C, 1'b1, 1'b0);
        check("lit_bp_second", s_out_data, B);
        cyc(1'b1, C, 1'b1, 1'b0);
        check("lit_bp_third", s_out_data, C);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("lit_bp_drain", s_out_valid, 1'b0);

        // Flush while two entries are held, with D offered in the same cycle.
        cyc(1'b1, A, 1'b0, 1'b0);
        cyc(1'b1, B, 1'b0, 1'b0);
        cyc(1'b1, D, 1'b0, 1'b1);
        check("lit_flush_v", s_out_valid, 1'b0);
        check("lit_flush_rdy", s_in_ready, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("lit_flush_noD", s_out_valid, 1'b0);

        // Flush in the same cycle as an output transfer.
        cyc(1'b1, A, 1'b0, 1'b0);
        cyc(1'b1, B, 1'b1, 1'b1);
        check("lit_flushxfer_v", s_out_valid, 1'b0);

        // SKID=0: in_ready follows out_ready combinationally while full.
        cyc(1'b1, A, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = B; out_ready = 1'b0; flush = 1'b0;
        #1;
        check("lit_n_rdy_blocked", n_in_ready, 1'b0);
        out_ready = 1'b1;
        #1;
        check("lit_n_rdy_comb", n_in_ready, 1'b1);
        @(posedge clk);
        #1;
        check("lit_n_replace", n_out_data, B);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset in mid-operation.
        cyc(1'b1, C, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("lit_async_rst_v", s_out_valid, 1'b0);
        check("lit_async_rst_d", s_out_data, '0);
        check("lit_async_rst_n", n_out_valid, 1'b0);
`ifdef PIPELINE_STAGE_REG_STATS_EN
        check("lit_stat_rst_stall", s_stall, 32'd0);
        check("lit_stat_rst_xfer", s_xfer, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Counters: 5 stall cycles, then 3 transfers, then a flush.
        cyc(1'b1, 70'h31, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, 70'h32, 1'b1, 1'b0);
        cyc(1'b1, 70'h33, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
`ifdef PIPELINE_STAGE_REG_STATS_EN
        check("lit_stat_stall5", s_stall, 32'd5);
        check("lit_stat_xfer3", s_xfer, 32'd3);
        check("lit_stat_n_stall5", n_stall, 32'd5);
`endif
        cyc(1'b1, 70'h34, 1'b0, 1'b1);
`ifdef PIPELINE_STAGE_REG_STATS_EN
        check("lit_stat_flush_stall", s_stall, 32'd5);
        check("lit_stat_flush_xfer", s_xfer, 32'd3);
        rst = 1'b0;
        #1;
        check("lit_stat_clear", s_xfer, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
`endif
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("lit_end_empty", s_out_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
